// File: rtl/mxm_mac_lanes.sv
// mxm_mac_lanes: multi-lane streaming dot-product accumulator.
// Each lane sums a_i*x_i over a vector of n_len accepted beats and emits one
// W-bit result per vector, wrapped or saturated, with a per-lane overflow flag.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no partial vector; next accepted beat is a first beat
//   ACC    | partial vector in progress, 0 < cnt < len
module mxm_mac_lanes #(
   parameter  int W      = 8,
   parameter  int LANES  = 4,
   parameter  int N_MAX  = 1024,
   parameter  int SIGNED = 0,
   localparam int CW     = $clog2(N_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   a,
   input  logic [LANES*W-1:0]   x,
   input  logic [CW-1:0]        n_len,
   input  logic                 sat_mode,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   y,
   output logic [LANES-1:0]     y_ovf
);

   localparam int ACC_W = 2 * W + CW;
   localparam logic [CW-1:0] NMAX_C = CW'(N_MAX);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;

   logic [CW-1:0]               r_cnt;
   logic [CW-1:0]               r_len;
   logic                        r_sat;
   logic [LANES-1:0][ACC_W-1:0] r_acc;

   logic                        r_out_valid;
   logic [LANES*W-1:0]          r_y;
   logic [LANES-1:0]            r_y_ovf;

   logic [CW-1:0]               w_len_in;
   logic [CW-1:0]               w_len_cur;
   logic                        w_sat_cur;
   logic                        w_is_last;
   logic                        w_accept;
   logic                        w_consume;
   logic                        w_acc_en;
   logic                        w_load;
   logic                        w_acc_clr;
   logic                        w_latch_cfg;

   logic [LANES-1:0][ACC_W-1:0] w_a_ext;
   logic [LANES-1:0][ACC_W-1:0] w_x_ext;
   logic [LANES-1:0][ACC_W-1:0] w_prod;
   logic [LANES-1:0][ACC_W-1:0] w_sum;
   logic [LANES-1:0][W-1:0]     w_sat_val;
   logic [LANES-1:0]            w_ovf;
   logic [LANES*W-1:0]          w_y_cvt;

   // Sanitise the requested length: zero means one beat, oversize clamps to N_MAX.
   always_comb begin
      w_len_in = n_len;
      if (n_len == '0) begin
         w_len_in = CW'(1);
      end else if (n_len > NMAX_C) begin
         w_len_in = NMAX_C;
      end
   end

   // Length and mode in force for the current beat: live inputs on a first beat,
   // latched copies afterwards. r_cnt is zero in IDLE, so one compare finds the last beat.
   always_comb begin
      w_len_cur = (r_state == S_IDLE) ? w_len_in : r_len;
      w_sat_cur = (r_state == S_IDLE) ? sat_mode : r_sat;
      w_is_last = (r_cnt == (w_len_cur - CW'(1)));
   end

   // Handshake: only a last beat can be held back, and only by an unconsumed result.
   always_comb begin
      in_ready  = rst && !clear && !(w_is_last && r_out_valid && !out_ready);
      w_accept  = in_valid && in_ready;
      w_consume = r_out_valid && out_ready;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_is_last) begin
               w_state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            if (clear || (w_accept && w_is_last)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes.
   always_comb begin
      w_acc_en    = w_accept && !w_is_last;
      w_load      = w_accept && w_is_last;
      w_acc_clr   = clear || w_load;
      w_latch_cfg = w_accept && (r_state == S_IDLE);
   end

   // Per-lane product, running sum and W-bit conversion of that sum.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_a_ext[i] = {{(ACC_W - W){(SIGNED != 0) && a[i*W + W - 1]}}, a[i*W +: W]};
         w_x_ext[i] = {{(ACC_W - W){(SIGNED != 0) && x[i*W + W - 1]}}, x[i*W +: W]};
         w_prod[i]  = w_a_ext[i] * w_x_ext[i];
         w_sum[i]   = r_acc[i] + w_prod[i];
         if (SIGNED != 0) begin
            // In range iff every bit from W-1 upward equals the sign bit.
            w_ovf[i]     = !((&w_sum[i][ACC_W-1:W-1]) || !(|w_sum[i][ACC_W-1:W-1]));
            w_sat_val[i] = w_sum[i][ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                                             : {1'b0, {(W-1){1'b1}}};
         end else begin
            w_ovf[i]     = |w_sum[i][ACC_W-1:W];
            w_sat_val[i] = {W{1'b1}};
         end
         w_y_cvt[i*W +: W] = (w_sat_cur && w_ovf[i]) ? w_sat_val[i] : w_sum[i][W-1:0];
      end
   end

   // Beat counter plus the length and mode latched on the first beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_len <= '0;
         r_sat <= 1'b0;
      end else begin
         if (w_acc_clr) begin
            r_cnt <= '0;
         end else if (w_acc_en) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_latch_cfg) begin
            r_len <= w_len_in;
            r_sat <= sat_mode;
         end
      end
   end

   // Full-width lane accumulators; cleared by abort or when a vector completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
      end else if (w_acc_clr) begin
         r_acc <= '0;
      end else if (w_acc_en) begin
         r_acc <= w_sum;
      end
   end

   // Result register: a new load wins over a same-cycle consume.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_y_ovf     <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_y         <= w_y_cvt;
         r_y_ovf     <= w_ovf;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign y_ovf     = r_y_ovf;

endmodule

// File: tb/tb_mxm_mac_lanes.sv
// Bench for mxm_mac_lanes: an unsigned and a signed instance (2 lanes, W=8,
// N_MAX=8) share one stimulus stream; a per-instance arithmetic model is
// compared on every falling edge, and hand-computed literals pin the model.
module tb_mxm_mac_lanes;

   localparam int W = 8;
   localparam int L = 2;
   localparam int NM = 8;
   localparam int CW = $clog2(NM + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [L*W-1:0]  a, x;
   logic [CW-1:0]   n_len;
   logic            sat_mode;
   logic            clear;
   logic            out_ready;

   logic            rdy_u, ov_u, rdy_s, ov_s;
   logic [L*W-1:0]  y_u, y_s;
   logic [L-1:0]    yo_u, yo_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mxm_mac_lanes #(.W(W), .LANES(L), .N_MAX(NM), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u),
      .a(a), .x(x), .n_len(n_len), .sat_mode(sat_mode), .clear(clear),
      .out_valid(ov_u), .out_ready(out_ready), .y(y_u), .y_ovf(yo_u));

   mxm_mac_lanes #(.W(W), .LANES(L), .N_MAX(NM), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
      .a(a), .x(x), .n_len(n_len), .sat_mode(sat_mode), .clear(clear),
      .out_valid(ov_s), .out_ready(out_ready), .y(y_s), .y_ovf(yo_s));

   // ---------------- behavioural model (index 0 unsigned, 1 signed) -------
   int          m_cnt [2];
   int          m_len [2];
   bit          m_sat [2];
   bit          m_ov  [2];
   longint      m_acc [2][L];
   logic [15:0] m_y   [2];
   logic [1:0]  m_yo  [2];

   function automatic int clampn(int n);
      if (n == 0) return 1;
      if (n > NM) return NM;
      return n;
   endfunction

   function automatic longint opv(logic [7:0] v, int s);
      if (s == 1) return longint'($signed(v));
      return longint'(v);
   endfunction

   function automatic bit exp_ready(int s);
      int le;
      if (!rst || clear) return 1'b0;
      le = (m_cnt[s] == 0) ? clampn(int'(n_len)) : m_len[s];
      if ((m_cnt[s] == le - 1) && m_ov[s] && !out_ready) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         for (int s = 0; s < 2; s++) begin
            if (!rst) begin
               m_cnt[s] = 0; m_len[s] = 0; m_sat[s] = 0; m_ov[s] = 0;
               m_y[s] = '0; m_yo[s] = '0;
               for (int l = 0; l < L; l++) m_acc[s][l] = 0;
            end else begin
               bit ld;
               ld = 1'b0;
               if (in_valid && exp_ready(s)) begin
                  if (m_cnt[s] == 0) begin
                     m_len[s] = clampn(int'(n_len));
                     m_sat[s] = sat_mode;
                  end
                  for (int l = 0; l < L; l++)
                     m_acc[s][l] += opv(a[l*8 +: 8], s) * opv(x[l*8 +: 8], s);
                  m_cnt[s]++;
                  if (m_cnt[s] == m_len[s]) begin
                     for (int l = 0; l < L; l++) begin
                        longint sum, lo, hi, v;
                        sum = m_acc[s][l];
                        lo = (s == 1) ? -128 : 0;
                        hi = (s == 1) ? 127 : 255;
                        m_yo[s][l] = (sum < lo) || (sum > hi);
                        v = sum;
                        if (m_sat[s]) v = (sum < lo) ? lo : ((sum > hi) ? hi : sum);
                        m_y[s][l*8 +: 8] = 8'(v);
                        m_acc[s][l] = 0;
                     end
                     m_cnt[s] = 0;
                     ld = 1'b1;
                  end
               end else if (clear) begin
                  m_cnt[s] = 0;
                  for (int l = 0; l < L; l++) m_acc[s][l] = 0;
               end
               if (ld) m_ov[s] = 1'b1;
               else if (m_ov[s] && out_ready) m_ov[s] = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("u.in_ready",  rdy_u, exp_ready(0));
         chk("u.out_valid", ov_u,  m_ov[0]);
         chk("u.y",         y_u,   m_y[0]);
         chk("u.y_ovf",     yo_u,  m_yo[0]);
         chk("s.in_ready",  rdy_s, exp_ready(1));
         chk("s.out_valid", ov_s,  m_ov[1]);
         chk("s.y",         y_s,   m_y[1]);
         chk("s.y_ovf",     yo_s,  m_yo[1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input logic [7:0] a0, x0, a1, x1);
      a = {a1, a0};
      x = {x1, x0};
      in_valid = 1'b1;
   endtask

   // Holds the driven beat until accepted; returns at posedge+1 after acceptance.
   task automatic beat();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (rdy_u) got = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_timeout: in_ready never rose within 50 cycles");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rst = 1'b0; in_valid = 1'b0; a = '0; x = '0; n_len = 4'd1;
      sat_mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", ov_u, 0);
      chk("rst_y",         y_u,  0);
      chk("rst_in_ready",  rdy_u, 0);
      rst = 1'b1;
      idle(1);

      // basic accumulate: 3*(2*3)=18, 3*(1*7)=21
      n_len = 4'd3; sat_mode = 1'b0;
      drv(8'd2, 8'd3, 8'd1, 8'd7);
      beat(); beat(); beat();
      in_valid = 1'b0;
      chk("basic_valid", ov_u, 1);
      chk("basic_y",     y_u, 16'h1512);
      chk("basic_ovf",   yo_u, 2'b00);
      chk("basic_y_s",   y_s, 16'h1512);
      idle(1);
      chk("basic_drop",  ov_u, 0);

      // wrap vs saturate: 4*16*16 = 1024
      n_len = 4'd4; sat_mode = 1'b0;
      drv(8'd16, 8'd16, 8'd16, 8'd16);
      repeat (4) beat();
      in_valid = 1'b0;
      chk("wrap_y",   y_u, 16'h0000);
      chk("wrap_ovf", yo_u, 2'b11);
      idle(1);
      sat_mode = 1'b1;
      drv(8'd16, 8'd16, 8'd16, 8'd16);
      repeat (4) beat();
      in_valid = 1'b0;
      chk("sat_y",    y_u, 16'hFFFF);
      chk("sat_ovf",  yo_u, 2'b11);
      chk("sat_y_s",  y_s, 16'h7F7F);
      idle(1);

      // signed: -3*5 + -100*2 = -215
      n_len = 4'd2; sat_mode = 1'b1;
      drv(8'hFD, 8'd5, 8'hFD, 8'd5); beat();
      drv(8'h9C, 8'd2, 8'h9C, 8'd2); beat();
      in_valid = 1'b0;
      chk("sgn_sat_y",   y_s, 16'h8080);
      chk("sgn_sat_ovf", yo_s, 2'b11);
      idle(1);
      sat_mode = 1'b0;
      drv(8'hFD, 8'd5, 8'hFD, 8'd5); beat();
      drv(8'h9C, 8'd2, 8'h9C, 8'd2); beat();
      in_valid = 1'b0;
      chk("sgn_wrap_y",   y_s, 16'h2929);
      chk("sgn_wrap_ovf", yo_s, 2'b11);
      idle(1);

      // backpressure: A=2 held, B's last beat stalls until A is consumed
      out_ready = 1'b0; n_len = 4'd2;
      drv(8'd1, 8'd1, 8'd1, 8'd1); beat(); beat();
      drv(8'd3, 8'd3, 8'd3, 8'd3); beat();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_stall", rdy_u, 0);
         @(posedge clk);
         #1;
      end
      chk("bp_hold_y", y_u, 16'h0202);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", rdy_u, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_b_valid", ov_u, 1);
      chk("bp_b_y",     y_u, 16'h1212);
      idle(1);

      // clear mid-vector with a pending result
      out_ready = 1'b0; n_len = 4'd1;
      drv(8'd5, 8'd5, 8'd5, 8'd5); beat();
      n_len = 4'd4;
      drv(8'd1, 8'd1, 8'd1, 8'd1); beat(); beat();
      drv(8'd7, 8'd7, 8'd7, 8'd7);
      clear = 1'b1;
      @(negedge clk);
      chk("clr_ready", rdy_u, 0);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_keep_valid", ov_u, 1);
      chk("clr_keep_y",     y_u, 16'h1919);
      out_ready = 1'b1;
      drv(8'd1, 8'd1, 8'd1, 8'd1);
      repeat (4) beat();
      in_valid = 1'b0;
      chk("clr_y", y_u, 16'h0404);
      idle(1);

      // length bounds: 0 -> 1 beat, 9 -> clamped to 8
      n_len = 4'd0;
      drv(8'd2, 8'd2, 8'd2, 8'd2); beat();
      in_valid = 1'b0;
      chk("len0_valid", ov_u, 1);
      chk("len0_y",     y_u, 16'h0404);
      idle(1);
      n_len = 4'd9;
      drv(8'd1, 8'd1, 8'd1, 8'd1);
      repeat (7) beat();
      chk("len9_not_yet", ov_u, 0);
      beat();
      in_valid = 1'b0;
      chk("len9_valid", ov_u, 1);
      chk("len9_y",     y_u, 16'h0808);
      idle(1);

      // async reset mid-vector, between edges
      out_ready = 1'b0; n_len = 4'd1;
      drv(8'd4, 8'd4, 8'd4, 8'd4); beat();
      n_len = 4'd4;
      drv(8'd3, 8'd3, 8'd3, 8'd3); beat(); beat();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid",   ov_u, 0);
      chk("arst_y",       y_u, 0);
      chk("arst_ovf",     yo_u, 0);
      chk("arst_ready",   rdy_u, 0);
      chk("arst_valid_s", ov_s, 0);
      @(posedge clk);
      #1;
      rst = 1'b1; out_ready = 1'b1; n_len = 4'd2;
      drv(8'd1, 8'd1, 8'd1, 8'd1); beat(); beat();
      in_valid = 1'b0;
      chk("arst_fresh_y", y_u, 16'h0202);
      idle(1);

      // back-to-back 1-beat vectors, no bubble
      n_len = 4'd1;
      drv(8'd1, 8'd2, 8'd1, 8'd2); beat();
      drv(8'd3, 8'd4, 8'd3, 8'd4); beat();
      chk("b2b_y2", y_u, 16'h0C0C);
      drv(8'd5, 8'd6, 8'd5, 8'd6); beat();
      in_valid = 1'b0;
      chk("b2b_y3",     y_u, 16'h1E1E);
      chk("b2b_valid",  ov_u, 1);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
